// File: rtl/register_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// register_pkg : operation encodings shared by all register-type blocks
// Rev 1.0
// ------------------------------------------------------------------
package register_pkg;

    typedef enum logic [2:0] {
        FUN_DEC     = 3'b000,
        FUN_INC     = 3'b001,
        FUN_LOAD    = 3'b010,
        FUN_CLEAR   = 3'b011,
        FUN_SHL     = 3'b100,
        FUN_SHR     = 3'b101,
        FUN_LOAD_LO = 3'b110,
        FUN_HOLD    = 3'b111
    } fun_sel_e;

endpackage
`default_nettype wire

// File: rtl/register_bank_if.sv
`default_nettype none
// ------------------------------------------------------------------
// register_bank_if : control, load and read-port bundle of register_bank
// Rev 1.0
// ------------------------------------------------------------------
interface register_bank_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0] E;
    logic [2:0]       FunSel;
    logic [WIDTH-1:0] In;
    logic [SEL_W-1:0] OutASel;
    logic [SEL_W-1:0] OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic [DEPTH-1:0] Zero;
    logic             Wrap;

    modport master (
        output E, FunSel, In, OutASel, OutBSel,
        input  OutA, OutB, Zero, Wrap
    );

    modport slave (
        input  E, FunSel, In, OutASel, OutBSel,
        output OutA, OutB, Zero, Wrap
    );

endinterface
`default_nettype wire

// File: rtl/register_cell.sv
`default_nettype none
// ------------------------------------------------------------------
// register_cell : one register with its operation mux and boundary detect
// Rev 1.0
// ------------------------------------------------------------------
module register_cell
    import register_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    input  wire logic             en,
    input  fun_sel_e              fun_sel,
    input  wire logic [WIDTH-1:0] load_data,
    output logic      [WIDTH-1:0] value,
    output logic                  boundary
);

    localparam int               c_half = WIDTH / 2;
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_ones = '1;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d  = value_q;
        boundary = 1'b0;
        if (en) begin
            case (fun_sel)
                FUN_DEC: begin
                    // Underflow either wraps to all-ones or clamps at zero
                    if (value_q == c_zero) begin
                        boundary = 1'b1;
                        value_d  = (SATURATE != 0) ? c_zero : c_ones;
                    end else begin
                        value_d  = value_q - c_one;
                    end
                end
                FUN_INC: begin
                    if (value_q == c_ones) begin
                        boundary = 1'b1;
                        value_d  = (SATURATE != 0) ? c_ones : c_zero;
                    end else begin
                        value_d  = value_q + c_one;
                    end
                end
                FUN_LOAD:    value_d = load_data;
                FUN_CLEAR:   value_d = c_zero;
                FUN_SHL:     value_d = {value_q[WIDTH-2:0], 1'b0};
                FUN_SHR:     value_d = {1'b0, value_q[WIDTH-1:1]};
                FUN_LOAD_LO: value_d = {value_q[WIDTH-1:c_half], load_data[c_half-1:0]};
                FUN_HOLD:    value_d = value_q;
                default:     value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// register_bank : DEPTH x WIDTH registers sharing one operation per edge
// Rev 1.0
// ------------------------------------------------------------------
module register_bank
    import register_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic  clock,
    input  wire logic  reset_n,
    register_bank_if.slave bus
);

    logic [WIDTH-1:0] cell_value [DEPTH];
    logic [DEPTH-1:0] cell_boundary;
    logic [DEPTH-1:0] zero_vec;
    fun_sel_e         fun_sel;
    logic             wrap_q;
    logic             wrap_d;

    assign fun_sel = fun_sel_e'(bus.FunSel);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_cell
            register_cell #(
                .WIDTH     (WIDTH),
                .SATURATE  (SATURATE),
                .RESET_VAL (RESET_VAL)
            ) u_cell (
                .clock     (clock),
                .reset_n   (reset_n),
                .en        (bus.E[i]),
                .fun_sel   (fun_sel),
                .load_data (bus.In),
                .value     (cell_value[i]),
                .boundary  (cell_boundary[i])
            );
        end
    endgenerate

    always_comb begin
        zero_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            zero_vec[i] = (cell_value[i] == '0);
        end
    end

    assign wrap_d = |cell_boundary;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.OutA = cell_value[bus.OutASel];
    assign bus.OutB = cell_value[bus.OutBSel];
    assign bus.Zero = zero_vec;
    assign bus.Wrap = wrap_q;

endmodule
`default_nettype wire

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of registers (power of two, >=2).
REQ-003 The block SHALL have parameter SATURATE, default 0; 0 = increment/decrement wrap, 1 = increment/decrement clamp.
REQ-004 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every register on reset.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 E  input  DEPTH  per-register enable mask; bit i enables register i.
REQ-008 FunSel  input  3  operation applied to every enabled register.
REQ-009 In  input  WIDTH  load data.
REQ-010 OutASel, OutBSel  input  clog2(DEPTH) each  read-port selects.
REQ-011 OutA, OutB  output  WIDTH each  combinational read of the selected register.
REQ-012 Zero  output  DEPTH  bit i high while register i equals 0 (combinational).
REQ-013 Wrap  output  1  registered one-cycle pulse: an enabled inc/dec overflowed, underflowed or clamped last edge.

Function
REQ-014 FunSel encodings SHALL be: 000 dec, 001 inc, 010 load In, 011 clear, 100 shift left 1 (LSB<-0), 101 logical shift right 1 (MSB<-0), 110 load In[WIDTH/2-1:0] into low half keeping high half, 111 hold.
REQ-015 A register with its E bit low SHALL retain its value regardless of FunSel.
REQ-016 All registers whose E bit is high SHALL perform the same FunSel operation on the same edge, each on its own current value.
REQ-017 SATURATE=0: inc of all-ones SHALL give 0 and dec of 0 SHALL give all-ones.
REQ-018 SATURATE=1: inc of all-ones SHALL hold all-ones and dec of 0 SHALL hold 0.
REQ-019 Wrap SHALL be high for exactly the cycle after any edge where an enabled register hit the REQ-017/018 boundary, otherwise low; non-inc/dec operations SHALL never set it.
REQ-020 Register update latency SHALL be one clock edge; OutA/OutB/Zero SHALL reflect the new value immediately after that edge.
REQ-021 OutASel==OutBSel SHALL be legal; both ports return the same value.
REQ-022 Reading a register being written on the same edge SHALL return the pre-edge value before the edge (no write-through bypass).
REQ-023 E all-zero or FunSel=111 SHALL leave all state unchanged, and Wrap SHALL be 0 next cycle.

Reset
REQ-024 reset_n low SHALL immediately, without waiting for clock, set every register to RESET_VAL and Wrap to 0.
REQ-025 While reset_n is low, E and FunSel SHALL be ignored; an operation in flight at reset assertion SHALL be discarded.
REQ-026 The first rising edge after reset_n deasserts SHALL perform normal operation.

Structure
REQ-027 FunSel encoding constants SHALL reside in shared package register_pkg, reused by all register-type blocks.
REQ-028 The per-register datapath (operation mux, saturation, boundary detect) SHALL be sub-module register_cell, instantiated DEPTH times via generate.
REQ-029 register_bank SHALL contain only the cell array, the read muxes, the Zero vector and the Wrap flop.

Verification (WIDTH=16, DEPTH=4)
REQ-030 Reset, then E=1111 FunSel=010 In=0x00FF -> all four regs 0x00FF; Zero=0000; Wrap=0.
REQ-031 Reg0=0xFFFF, E=0001 FunSel=001: SATURATE=0 -> reg0=0x0000, Zero[0]=1, Wrap pulses 1 cycle; SATURATE=1 -> reg0=0xFFFF, Wrap pulses.
REQ-032 Reg2=0xA5A5, E=0100 FunSel=110 In=0x1234 -> reg2=0xA534; then FunSel=101 -> 0x529A; other regs unchanged.
REQ-033 Reg1=0x8001, E=0010 FunSel=100 -> reg1=0x0002, Wrap=0; OutASel=OutBSel=1 -> both read 0x0002.
REQ-034 E=1111 FunSel=001 mid-stream, reset_n low between edges -> all regs RESET_VAL at once, Wrap=0, no increment after release until next enabled edge.
REQ-035 Reg3=0x0000, E=1000 FunSel=000 with OutASel=3 -> OutA=0x0000 before edge, 0xFFFF after (SATURATE=0); E=0000 next cycle -> unchanged, Wrap=0.
